ispm_stream_loader: RTL

//  Upstream writer for the instruction-scratchpad dual-port BRAM. Takes a byte stream
//  (valid/ready, e.g. from the debug UART) carrying a framed program image and

---
 rtl/ispm_stream_loader_pkg.sv | 15 +
 rtl/ispm_stream_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ispm_stream_loader_pkg.sv
// Shared types and constants for the instruction-scratchpad stream loader.
package ispm_stream_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StCsum,
    StErr
  } state_e;

  localparam logic [7:0]  SyncDefault  = 8'hA5;
  localparam int unsigned BytesPerWord = 4;

endpackage

// File: rtl/ispm_stream_loader.sv
// Byte-stream frame loader writing 32-bit LE words into the ISPM BRAM write port.
// Define ISPM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module ispm_stream_loader
  import ispm_stream_loader_pkg::*;
#(
  parameter int unsigned DATA = 32,
  parameter int unsigned ADDR = 10,
  parameter logic [7:0]  SYNC = SyncDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            mem_wr,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  output logic            core_hold,
  output logic            done,
  output logic            error
);

  localparam logic [16:0] DepthW = 17'd1 << ADDR;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       hdr_q, hdr_d;
  logic [15:0]       words_q, words_d;
  logic [7:0]        csum_q, csum_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA-1:0]   mem_din_q, mem_din_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [15:0] hdr_addr;
  logic [15:0] hdr_cnt;
  logic [16:0] hdr_end;
  logic        hdr_bad;

  // Header fields are valid when the 4th header byte is on in_data.
  assign hdr_addr = hdr_q[15:0];
  assign hdr_cnt  = {in_data, hdr_q[23:16]};
  assign hdr_end  = {1'b0, hdr_addr} + {1'b0, hdr_cnt};
  assign hdr_bad  = ((hdr_addr >> ADDR) != 16'd0) || (hdr_end > DepthW);

  assign in_ready = 1'b1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hdr_d      = hdr_q;
    words_d    = words_q;
    csum_d     = csum_q;
    mem_wr_d   = 1'b0;
    mem_addr_d = mem_wr_q ? mem_addr_q + ADDR'(1) : mem_addr_q;
    mem_din_d  = mem_din_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    error_d    = error_q;

    case (state_q)
      StIdle: begin
        if (in_valid && in_data == SYNC) begin
          state_d = StHdr;
          idx_d   = 2'd0;
          csum_d  = 8'h00;
          error_d = 1'b0;
          hold_d  = 1'b1;
        end
      end
      StHdr: begin
        if (in_valid) begin
          csum_d = csum_q ^ in_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q != 2'd3) begin
            hdr_d = {in_data, hdr_q[23:8]};
          end else begin
            words_d    = hdr_cnt;
            mem_addr_d = hdr_addr[ADDR-1:0];
            if (hdr_bad) begin
              state_d = StErr;
            end else if (hdr_cnt == 16'd0) begin
`ifdef ISPM_LOADER_CHECKSUM_EN
              state_d = StCsum;
`else
              done_d  = 1'b1;
              hold_d  = 1'b0;
              state_d = StIdle;
`endif
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (words_q == 16'd0) begin
          // Final write is on the bus this cycle; finish the frame.
          done_d  = 1'b1;
          hold_d  = 1'b0;
          state_d = StIdle;
        end else if (in_valid) begin
          csum_d = csum_q ^ in_data;
          idx_d  = idx_q + 2'd1;
          mem_din_d[{idx_q, 3'b000} +: 8] = in_data;
          if (idx_q == 2'd3) begin
            mem_wr_d = 1'b1;
            words_d  = words_q - 16'd1;
`ifdef ISPM_LOADER_CHECKSUM_EN
            if (words_q == 16'd1) state_d = StCsum;
`endif
          end
        end
      end
      StCsum: begin
        if (in_valid) begin
          if (in_data == csum_q) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StErr;
          end
        end
      end
      StErr: begin
        error_d = 1'b1;
        hold_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      hdr_q      <= 24'd0;
      words_q    <= 16'd0;
      csum_q     <= 8'h00;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hdr_q      <= hdr_d;
      words_q    <= words_d;
      csum_q     <= csum_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign core_hold = hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
